// File: rtl/ps_stck_pkg.sv
// Shared definitions for the ps stack controller.
//   - FSM state encoding for the controller
//   - default entry / pointer widths
//   - ureg address of the stack slot (also used by the ureg decoder)
package ps_stck_pkg;

    localparam int unsigned PS_STCK_DATA_W = 16;
    localparam int unsigned PS_STCK_PTR_W  = 4;

    // ureg read/write address that maps onto push/pop of the stack
    localparam logic [4:0] PS_STCK_UREG_ADDR = 5'b00100;

    typedef enum logic [0:0] {
        StIdle   = 1'b0,
        StRefill = 1'b1
    } ps_stck_state_e;

endpackage

// File: rtl/ps_stck_ram.sv
// Backing store for the stack: DEPTH-1 words below the cached TOS register.
// Ports:
//   clk            system clock
//   we/waddr/wdata write port
//   re/raddr       synchronous read request; rdata valid one cycle later
//   rdata          registered read data (holds when re is low)
// No reset: contents are undefined until written.
module ps_stck_ram
    import ps_stck_pkg::*;
#(
    parameter int unsigned DATA_W = PS_STCK_DATA_W,
    parameter int unsigned PTR_W  = PS_STCK_PTR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [PTR_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned WORDS = (2 ** PTR_W) - 1;

    logic [DATA_W-1:0] mem [WORDS];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ps_stck_ctrl.sv
// Hardware stack controller for the ureg stack slot.
// Keeps the top of stack in a register and spills deeper entries to RAM.
// A push writes the old TOS back to RAM; a pop with more entries below
// refills the TOS from RAM, stalling the sequencer (busy) for one cycle.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   ps_pshstck/popstck push / pop strobes, ps_pshdata push value
//   ps_stck_flg_clr    clears sticky ovf/unf flags (a same-cycle set wins)
//   ps_tos             registered top of stack
//   ps_popdata(_vld)   popped value and its one-cycle valid pulse
//   ps_stck_cnt        number of valid entries (0..DEPTH)
//   ps_stck_empty/full occupancy compares on the count register
//   ps_stck_busy       refill in progress, strobes ignored
//   ps_stck_ovf/unf    sticky overflow / underflow flags
module ps_stck_ctrl
    import ps_stck_pkg::*;
#(
    parameter int unsigned DATA_W = PS_STCK_DATA_W,
    parameter int unsigned PTR_W  = PS_STCK_PTR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ps_pshstck,
    input  logic              ps_popstck,
    input  logic [DATA_W-1:0] ps_pshdata,
    input  logic              ps_stck_flg_clr,
    output logic [DATA_W-1:0] ps_tos,
    output logic [DATA_W-1:0] ps_popdata,
    output logic              ps_popdata_vld,
    output logic [PTR_W:0]    ps_stck_cnt,
    output logic              ps_stck_empty,
    output logic              ps_stck_full,
    output logic              ps_stck_busy,
    output logic              ps_stck_ovf,
    output logic              ps_stck_unf
);

    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(2 ** PTR_W);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO   = CNT_W'(2);

    ps_stck_state_e    state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] tos_q, tos_d;
    logic [DATA_W-1:0] popdata_q, popdata_d;
    logic              vld_q, vld_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              ovf_set, unf_set;

    logic              ram_we;
    logic [PTR_W-1:0]  ram_waddr;
    logic              ram_re;
    logic [PTR_W-1:0]  ram_raddr;
    logic [DATA_W-1:0] ram_rdata;

    logic empty, full;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CNT_DEPTH);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tos_d     = tos_q;
        popdata_d = popdata_q;
        vld_d     = 1'b0;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        ram_we    = 1'b0;
        ram_waddr = PTR_W'(cnt_q - CNT_ONE);
        ram_re    = 1'b0;
        ram_raddr = PTR_W'(cnt_q - CNT_TWO);

        unique case (state_q)
            StIdle: begin
                if (ps_pshstck && ps_popstck) begin
                    if (empty) begin
                        // Nothing to pop: behaves as a plain push into an empty stack
                        tos_d   = ps_pshdata;
                        cnt_d   = CNT_ONE;
                        unf_set = 1'b1;
                    end else begin
                        // Replace TOS in place; RAM and count untouched
                        popdata_d = tos_q;
                        vld_d     = 1'b1;
                        tos_d     = ps_pshdata;
                    end
                end else if (ps_pshstck) begin
                    if (full) begin
                        ovf_set = 1'b1;
                    end else begin
                        ram_we = !empty;
                        tos_d  = ps_pshdata;
                        cnt_d  = cnt_q + CNT_ONE;
                    end
                end else if (ps_popstck) begin
                    if (empty) begin
                        unf_set = 1'b1;
                    end else if (cnt_q == CNT_ONE) begin
                        popdata_d = tos_q;
                        vld_d     = 1'b1;
                        tos_d     = '0;
                        cnt_d     = '0;
                    end else begin
                        // Launch the read of the next-deeper entry; it lands in REFILL
                        popdata_d = tos_q;
                        vld_d     = 1'b1;
                        cnt_d     = cnt_q - CNT_ONE;
                        ram_re    = 1'b1;
                        state_d   = StRefill;
                    end
                end
            end
            StRefill: begin
                tos_d   = ram_rdata;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Set has priority over clear
        ovf_d = (ovf_q && !ps_stck_flg_clr) || ovf_set;
        unf_d = (unf_q && !ps_stck_flg_clr) || unf_set;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            tos_q     <= '0;
            popdata_q <= '0;
            vld_q     <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tos_q     <= tos_d;
            popdata_q <= popdata_d;
            vld_q     <= vld_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    ps_stck_ram #(
        .DATA_W (DATA_W),
        .PTR_W  (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (tos_q),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    assign ps_tos         = tos_q;
    assign ps_popdata     = popdata_q;
    assign ps_popdata_vld = vld_q;
    assign ps_stck_cnt    = cnt_q;
    assign ps_stck_empty  = empty;
    assign ps_stck_full   = full;
    assign ps_stck_busy   = (state_q == StRefill);
    assign ps_stck_ovf    = ovf_q;
    assign ps_stck_unf    = unf_q;

endmodule

// File: tb/tb_ps_stck_ctrl.sv
// Directed bench for ps_stck_ctrl: a vector table for single-cycle steps,
// plus hand-written fill/overflow/drain sequences.
module tb_ps_stck_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        ps_pshstck;
    logic        ps_popstck;
    logic [15:0] ps_pshdata;
    logic        ps_stck_flg_clr;
    logic [15:0] ps_tos;
    logic [15:0] ps_popdata;
    logic        ps_popdata_vld;
    logic [4:0]  ps_stck_cnt;
    logic        ps_stck_empty;
    logic        ps_stck_full;
    logic        ps_stck_busy;
    logic        ps_stck_ovf;
    logic        ps_stck_unf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ps_stck_ctrl #(
        .DATA_W (16),
        .PTR_W  (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .ps_pshstck      (ps_pshstck),
        .ps_popstck      (ps_popstck),
        .ps_pshdata      (ps_pshdata),
        .ps_stck_flg_clr (ps_stck_flg_clr),
        .ps_tos          (ps_tos),
        .ps_popdata      (ps_popdata),
        .ps_popdata_vld  (ps_popdata_vld),
        .ps_stck_cnt     (ps_stck_cnt),
        .ps_stck_empty   (ps_stck_empty),
        .ps_stck_full    (ps_stck_full),
        .ps_stck_busy    (ps_stck_busy),
        .ps_stck_ovf     (ps_stck_ovf),
        .ps_stck_unf     (ps_stck_unf)
    );

    typedef struct {
        logic        rst;
        logic        psh;
        logic        pop;
        logic        clr;
        logic [15:0] din;
        logic [15:0] tos;
        logic [15:0] pd;
        logic        vld;
        logic [4:0]  cnt;
        logic        busy;
        logic        ovf;
        logic        unf;
    } vec_t;

    vec_t vecs [25];

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic psh, input logic pop,
                        input logic clr, input logic [15:0] din);
        @(negedge clk);
        reset           = rst;
        ps_pshstck      = psh;
        ps_popstck      = pop;
        ps_stck_flg_clr = clr;
        ps_pshdata      = din;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input int idx, input logic [15:0] tos, input logic [15:0] pd,
                           input logic vld, input logic [4:0] cnt, input logic busy,
                           input logic ovf, input logic unf);
        chk("tos", idx, 32'(ps_tos), 32'(tos));
        chk("popdata", idx, 32'(ps_popdata), 32'(pd));
        chk("vld", idx, 32'(ps_popdata_vld), 32'(vld));
        chk("cnt", idx, 32'(ps_stck_cnt), 32'(cnt));
        chk("busy", idx, 32'(ps_stck_busy), 32'(busy));
        chk("ovf", idx, 32'(ps_stck_ovf), 32'(ovf));
        chk("unf", idx, 32'(ps_stck_unf), 32'(unf));
        chk("empty", idx, 32'(ps_stck_empty), 32'(cnt == 5'd0));
        chk("full", idx, 32'(ps_stck_full), 32'(cnt == 5'd16));
    endtask

    initial begin
        reset = 1'b1; ps_pshstck = 1'b0; ps_popstck = 1'b0;
        ps_stck_flg_clr = 1'b0; ps_pshdata = '0;

        //         rst   psh   pop   clr   din       tos       pd        vld   cnt    busy  ovf   unf
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h1111, 16'h1111, 16'h0000, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h2222, 16'h2222, 16'h0000, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h3333, 16'h3333, 16'h0000, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h3333, 16'h3333, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h2222, 16'h3333, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'hABCD, 16'hABCD, 16'h2222, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hABCD, 16'h2222, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'hABCD, 16'hABCD, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h1111, 16'hABCD, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h1111, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h1111, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h1111, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h1111, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h5555, 16'h5555, 16'h1111, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h5555, 16'h1111, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h6666, 16'h6666, 16'h1111, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h6666, 16'h6666, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0};
        // push during refill: ignored
        vecs[18] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h7777, 16'h5555, 16'h6666, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0};
        vecs[19] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h8888, 16'h8888, 16'h6666, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0};
        vecs[20] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h8888, 16'h8888, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0};
        // push+pop during refill: ignored
        vecs[21] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h9999, 16'h5555, 16'h8888, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0};
        vecs[22] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'hAAAA, 16'hAAAA, 16'h8888, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0};
        vecs[23] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'hAAAA, 16'hAAAA, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0};
        // reset mid-refill
        vecs[24] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 25; i++) begin
            step(vecs[i].rst, vecs[i].psh, vecs[i].pop, vecs[i].clr, vecs[i].din);
            chk_all(i, vecs[i].tos, vecs[i].pd, vecs[i].vld, vecs[i].cnt, vecs[i].busy,
                    vecs[i].ovf, vecs[i].unf);
        end

        // Fill to depth 16, values 0x1000..0x100F
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 16'h1000 + 16'(i));
            chk("fill_cnt", 100 + i, 32'(ps_stck_cnt), 32'(i + 1));
            chk("fill_busy", 100 + i, 32'(ps_stck_busy), 32'd0);
        end
        chk("fill_full", 116, 32'(ps_stck_full), 32'd1);

        // Overflow push: flagged, state unchanged
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'hDEAD);
        chk_all(200, 16'h100F, 16'h0000, 1'b0, 5'd16, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        chk_all(201, 16'h100F, 16'h0000, 1'b0, 5'd16, 1'b0, 1'b0, 1'b0);

        // Drain all 16 in LIFO order
        for (int k = 0; k < 16; k++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
            chk("drain_pd", 300 + k, 32'(ps_popdata), 32'(16'h100F - 16'(k)));
            chk("drain_vld", 300 + k, 32'(ps_popdata_vld), 32'd1);
            chk("drain_cnt", 300 + k, 32'(ps_stck_cnt), 32'(15 - k));
            if (k < 15) begin
                chk("drain_busy", 300 + k, 32'(ps_stck_busy), 32'd1);
                step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
                chk("drain_tos", 300 + k, 32'(ps_tos), 32'(16'h100E - 16'(k)));
                chk("drain_busy_lo", 300 + k, 32'(ps_stck_busy), 32'd0);
            end
        end
        chk_all(400, 16'h0000, 16'h1000, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps_stck_ctrl.md
Name: ps_stck_ctrl

Overview:
- Hardware stack controller behind the universal-register stack slot (ureg write/read address 5'b00100).
- The ureg decoder issues push and pop strobes. This block owns the stack pointer, a cached top-of-stack (TOS) register and the backing RAM.
- It sequences RAM writeback and refill, stalls the program sequencer during refill, and flags overflow and underflow.

Parameters:
- DATA_W, 16, width of a stack entry (ureg data bus width).
- PTR_W, 4, pointer width. Total stack depth is DEPTH = 2**PTR_W entries: the TOS register plus DEPTH-1 RAM words.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ps_pshstck  in  1  push strobe from the ureg decoder, sampled each clk
- ps_popstck  in  1  pop strobe from the ureg decoder, sampled each clk
- ps_pshdata  in  DATA_W  push data from the ureg read bus, valid with ps_pshstck
- ps_stck_flg_clr  in  1  clears the sticky ovf/unf flags
- ps_tos  out  DATA_W  current top of stack (registered)
- ps_popdata  out  DATA_W  popped value (registered)
- ps_popdata_vld  out  1  one-cycle pulse; ps_popdata is valid
- ps_stck_cnt  out  PTR_W+1  number of valid entries, 0..DEPTH
- ps_stck_empty  out  1  high when ps_stck_cnt==0
- ps_stck_full  out  1  high when ps_stck_cnt==DEPTH
- ps_stck_busy  out  1  refill in progress; requests are not accepted
- ps_stck_ovf  out  1  sticky: push attempted while full
- ps_stck_unf  out  1  sticky: pop attempted while empty

Behaviour:
- Reset values:
  - cnt=0, ps_tos=0, ps_popdata=0, ps_popdata_vld=0, ovf=0, unf=0, state=IDLE.
  - RAM contents are not reset.
  - Reset mid-refill aborts the refill, and the state returns to IDLE.
- FSM has two states: IDLE and REFILL. ps_stck_busy = (state==REFILL), decoded from the state register.
- In REFILL, push and pop strobes are ignored with no side effects. The sequencer holds them until busy drops.
- IDLE, push only, not full:
  - If cnt>0, ram[cnt-1] <= ps_tos.
  - ps_tos <= ps_pshdata; cnt <= cnt+1.
  - Single cycle; the new TOS is visible the next cycle.
- IDLE, push while full: ovf <= 1. cnt, TOS and RAM are unchanged.
- IDLE, pop only, cnt>=2:
  - ps_popdata <= ps_tos; vld pulses the next cycle; cnt <= cnt-1.
  - RAM read address cnt-2 is launched this cycle (synchronous read, 1-cycle latency); go to REFILL.
  - In REFILL: ps_tos <= ram_q; return to IDLE.
  - A pop therefore costs 2 cycles, with busy high for exactly 1 cycle.
  - During REFILL, ps_tos still shows the old TOS and must not be consumed.
- IDLE, pop with cnt==1: ps_popdata <= ps_tos, vld pulses, ps_tos <= 0, cnt <= 0. No refill; stay in IDLE.
- IDLE, pop while empty: unf <= 1, vld stays 0, ps_popdata is unchanged.
- IDLE, push and pop together with cnt>=1 (replace):
  - ps_popdata <= ps_tos and vld pulses.
  - ps_tos <= ps_pshdata.
  - cnt and RAM are unchanged; no refill.
- IDLE, push and pop together with cnt==0: treat as a push, and also set unf.
- Sticky flags: ps_stck_flg_clr clears both flags. If a set condition and clear occur in the same cycle, set wins.
- ps_stck_empty and ps_stck_full are combinational compares on the cnt register.
- Count arithmetic is PTR_W+1 bits; it never wraps, because overflow and underflow are blocked.

Decomposition:
- Package ps_stck_pkg holds:
  - the FSM state encoding (IDLE=1'b0, REFILL=1'b1);
  - the default DATA_W and PTR_W;
  - the stack ureg address constant 5'b00100, shared with the ureg decoder.
- Sub-module ps_stck_ram:
  - DEPTH-1 words of DATA_W, one write port and one synchronous-read port, same clk.
  - No reset.
  - The controller never reads and writes the same address in one cycle.

Test Plan:
- Reset, then push 0x1111, 0x2222, 0x3333 on consecutive cycles -> ps_tos=0x3333, cnt=3, busy never asserted.
- From that state, pop -> next cycle popdata=0x3333 with vld=1 and busy=1; following cycle ps_tos=0x2222, cnt=2, busy=0.
- Push/pop together with TOS=0x2222 and pshdata=0xABCD -> popdata=0x2222, vld=1, ps_tos=0xABCD, cnt=2, no busy.
- Fill to DEPTH=16, then push 0xDEAD -> ovf=1, cnt=16, ps_tos unchanged. Pop all 16 -> LIFO order verified, ending with empty=1 and ps_tos=0.
- Pop while empty -> unf=1, vld=0. Assert flg_clr together with a new empty pop -> unf stays 1. flg_clr alone -> ovf=unf=0.
- Pop issued, then reset during REFILL -> next cycle cnt=0, ps_tos=0, busy=0. Strobes issued during REFILL (no reset) -> ignored, cnt unchanged.
